// File: rtl/source_codeblock_pkg.sv
// Shared step encodings and the constant-folded form of the codeblock expression.
package source_codeblock_pkg;

    localparam int STEP_W = 3;

    // Source program (MODE=0) steps
    localparam logic [STEP_W-1:0] STEP_LOAD     = 3'd0;
    localparam logic [STEP_W-1:0] STEP_DOUBLE   = 3'd1;
    localparam logic [STEP_W-1:0] STEP_SUB_SQR  = 3'd2;
    localparam logic [STEP_W-1:0] STEP_DIVIDE   = 3'd3;
    localparam logic [STEP_W-1:0] STEP_MULTIPLY = 3'd4;
    localparam logic [STEP_W-1:0] STEP_HALT_SRC = 3'd5;

    // Folded target program (MODE=1) steps
    localparam logic [STEP_W-1:0] STEP_FOLD     = 3'd1;
    localparam logic [STEP_W-1:0] STEP_HALT_TGT = 3'd2;

    // x = (2*a-1) * ((a*a)/a), every intermediate truncated to 'width' bits,
    // with a zero divisor giving a zero quotient.
    function automatic logic [63:0] cb_expr(input logic [63:0] a, input int unsigned width);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] t2;
        logic [63:0] t3;
        logic [63:0] t4;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        am   = a & mask;
        t2   = ((am << 1) - 64'd1) & mask;
        t3   = (am * am) & mask;
        t4   = (am == 64'd0) ? 64'd0 : ((t3 / am) & mask);
        return (t2 * t4) & mask;
    endfunction

endpackage

// File: rtl/source_codeblock_param_cb_divider.sv
// Combinational unsigned divider; a zero divisor yields a zero quotient.
module cb_divider #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient
);

    assign quotient = (divisor == '0) ? '0 : (dividend / divisor);

endmodule

// File: rtl/source_codeblock_param.sv
// Stutter-tolerant evaluation of x = (2*a-1)*((a*a)/a), either as the
// multi-step source program (MODE=0) or the folded target program (MODE=1).
module source_codeblock_param
    import source_codeblock_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stutter_in,
    input  logic              restart,
    input  logic [WIDTH-1:0]  a_in,
    output logic [WIDTH-1:0]  x,
    output logic              stutter,
    output logic              done,
    output logic [STEP_W-1:0] step
);

    localparam logic [STEP_W-1:0] STEP_HALT = (MODE == 0) ? STEP_HALT_SRC : STEP_HALT_TGT;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] t1_reg;
    logic [WIDTH-1:0] t2_reg;
    logic [WIDTH-1:0] t3_reg;
    logic [WIDTH-1:0] t4_reg;
    logic [WIDTH-1:0] quot;

    // t3/a_reg for the divide step
    cb_divider #(.WIDTH(WIDTH)) u_div (
        .dividend (t3_reg),
        .divisor  (a_reg),
        .quotient (quot)
    );

    // Program state: advances one step per non-stutter edge, everything holds on stutter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            t1_reg  <= '0;
            t2_reg  <= '0;
            t3_reg  <= '0;
            t4_reg  <= '0;
            x       <= '0;
            stutter <= 1'b0;
            done    <= 1'b0;
            step    <= STEP_LOAD;
        end else begin
            stutter <= stutter_in;
            if (!stutter_in) begin
                if (MODE == 0) begin
                    case (step)
                        STEP_LOAD: begin
                            a_reg <= a_in;
                            step  <= STEP_DOUBLE;
                        end
                        STEP_DOUBLE: begin
                            t1_reg <= a_reg << 1;
                            step   <= STEP_SUB_SQR;
                        end
                        STEP_SUB_SQR: begin
                            t2_reg <= t1_reg - WIDTH'(1);
                            t3_reg <= a_reg * a_reg;
                            step   <= STEP_DIVIDE;
                        end
                        STEP_DIVIDE: begin
                            t4_reg <= quot;
                            step   <= STEP_MULTIPLY;
                        end
                        STEP_MULTIPLY: begin
                            x    <= t2_reg * t4_reg;
                            done <= 1'b1;
                            step <= STEP_HALT;
                        end
                        STEP_HALT: begin
                            if (restart) begin
                                step <= STEP_LOAD;
                                done <= 1'b0;
                            end
                        end
                        // Unused encodings fall into halt with done untouched
                        default: step <= STEP_HALT;
                    endcase
                end else begin
                    case (step)
                        STEP_LOAD: begin
                            a_reg <= a_in;
                            step  <= STEP_FOLD;
                        end
                        STEP_FOLD: begin
                            x    <= WIDTH'(cb_expr(64'(a_reg), WIDTH));
                            done <= 1'b1;
                            step <= STEP_HALT;
                        end
                        STEP_HALT: begin
                            if (restart) begin
                                step <= STEP_LOAD;
                                done <= 1'b0;
                            end
                        end
                        default: step <= STEP_HALT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_source_codeblock_param.sv
// Directed bench pairing a source (MODE=0) and a folded (MODE=1) instance on shared inputs.
module tb_source_codeblock_param;

    logic       clk;
    logic       rst;
    logic       stutter_in;
    logic       restart;
    logic [7:0] a_in;
    logic [7:0] x0, x1;
    logic       stutter0, stutter1;
    logic       done0, done1;
    logic [2:0] step0, step1;

    int tests_run = 0;
    int tests_failed = 0;

    source_codeblock_param #(.WIDTH(8), .MODE(0)) dut_src (
        .clk(clk), .rst(rst), .stutter_in(stutter_in), .restart(restart), .a_in(a_in),
        .x(x0), .stutter(stutter0), .done(done0), .step(step0)
    );

    source_codeblock_param #(.WIDTH(8), .MODE(1)) dut_tgt (
        .clk(clk), .rst(rst), .stutter_in(stutter_in), .restart(restart), .a_in(a_in),
        .x(x1), .stutter(stutter1), .done(done1), .step(step1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Assert reset away from an edge, check the asynchronous clear, then release
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check({tag, "_x0"}, 32'(x0), 0);
        check({tag, "_step0"}, 32'(step0), 0);
        check({tag, "_done0"}, 32'(done0), 0);
        check({tag, "_stut0"}, 32'(stutter0), 0);
        check({tag, "_x1"}, 32'(x1), 0);
        check({tag, "_done1"}, 32'(done1), 0);
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        stutter_in = 1'b0;
        restart    = 1'b0;
        a_in       = 8'd0;

        // a=3, no stutter: target done at edge 2, source at edge 5, x=15
        do_reset("rst0");
        a_in = 8'd3;
        tick(2);
        check("a3_step0_e2", 32'(step0), 2);
        check("a3_done1_e2", 32'(done1), 1);
        check("a3_x1_e2", 32'(x1), 15);
        tick(2);
        check("a3_step0_e4", 32'(step0), 4);
        check("a3_done0_e4", 32'(done0), 0);
        tick(1);
        check("a3_done0_e5", 32'(done0), 1);
        check("a3_x0_e5", 32'(x0), 15);
        check("a3_step0_e5", 32'(step0), 5);
        check("a3_step1_halt", 32'(step1), 2);

        // Three stutter cycles during step2: done moves to edge 8
        do_reset("rst1");
        a_in = 8'd3;
        tick(2);
        stutter_in = 1'b1;
        check("stut_lag", 32'(stutter0), 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("stut_step_%0d", i), 32'(step0), 2);
            check($sformatf("stut_out_%0d", i), 32'(stutter0), 1);
        end
        stutter_in = 1'b0;
        tick(1);
        check("stut_release", 32'(stutter0), 0);
        check("stut_step_e6", 32'(step0), 3);
        tick(1);
        check("stut_done_e7", 32'(done0), 0);
        tick(1);
        check("stut_done_e8", 32'(done0), 1);
        check("stut_x_e8", 32'(x0), 15);

        // a=0: 255*0 = 0, no X anywhere
        do_reset("rst2");
        a_in = 8'd0;
        tick(5);
        check("a0_x0", 32'(x0), 0);
        check("a0_done0", 32'(done0), 1);
        check("a0_x1", 32'(x1), 0);
        check("a0_done1", 32'(done1), 1);
        check("a0_step0", 32'(step0), 5);

        // a=20: 39*7=273 -> 17; a_in changes after sampling must not matter
        do_reset("rst3");
        a_in = 8'd20;
        tick(1);
        a_in = 8'd99;
        tick(4);
        check("a20_x0", 32'(x0), 17);
        check("a20_x1", 32'(x1), 17);
        check("a20_done0", 32'(done0), 1);

        // Restart under stutter is ignored
        a_in       = 8'd2;
        restart    = 1'b1;
        stutter_in = 1'b1;
        tick(1);
        check("rs_stut_step0", 32'(step0), 5);
        check("rs_stut_done0", 32'(done0), 1);
        // Restart takes effect; x holds until overwritten
        stutter_in = 1'b0;
        tick(1);
        restart = 1'b0;
        check("rs_step0", 32'(step0), 0);
        check("rs_done0", 32'(done0), 0);
        check("rs_x0_hold", 32'(x0), 17);
        check("rs_step1", 32'(step1), 0);
        tick(2);
        check("rs_x1", 32'(x1), 6);
        check("rs_done1", 32'(done1), 1);
        tick(3);
        check("rs_x0", 32'(x0), 6);
        check("rs_done0_end", 32'(done0), 1);

        // Restart, run to step3, then reset abandons the program
        a_in    = 8'd3;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(3);
        check("mid_step0", 32'(step0), 3);
        check("mid_x0_prev", 32'(x0), 6);
        do_reset("rst_mid");
        a_in = 8'd3;
        tick(5);
        check("rerun_x0", 32'(x0), 15);
        check("rerun_done0", 32'(done0), 1);
        check("rerun_x1", 32'(x1), 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
